mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 73 +++++++
 tb/tb_mem_stage.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall constants and bus layouts for the
// memory-access stage. Struct field order matches the bit layout of the
// EX->MEM, MEM->WB and MEM->RF buses (first field = MSBs).
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD  = 151;
  localparam int MEM_TO_WB_WD  = 136;
  localparam int MEM_TO_RF_WD  = 104;
  localparam int HILO_WD       = 66;
  localparam int STALL_BUS     = 6;

  // Stall vector bit positions and levels
  localparam int   STALL_EX_MEM = 3;
  localparam int   STALL_MEM_WB = 4;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  // mem_op, MSB first
  typedef struct packed {
    logic lb, lbu, lh, lhu, lw, sb, sh, sw;
  } mem_op_t;

  typedef struct packed {
    mem_op_t              mem_op;
    logic [HILO_WD-1:0]   hilo_bus;
    logic [31:0]          pc;
    logic                 ram_en;
    logic                 ram_wen;
    logic [3:0]           ram_sel;
    logic                 sel_rf_res;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [HILO_WD-1:0]   hilo_bus;
    logic [31:0]          pc;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic [HILO_WD-1:0]   hilo_bus;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
  } mem_to_rf_t;

  function automatic logic is_load(mem_op_t op);
    return op.lb | op.lbu | op.lh | op.lhu | op.lw;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-facing signals of the memory stage.
//   stall           global stall vector (bit 3 EX->MEM, bit 4 MEM->WB)
//   ex_to_mem_bus   registered into the stage
//   data_sram_rdata SRAM read data, one cycle after the EX request
//   mem_to_wb_bus   to writeback
//   mem_to_rf_bus   bypass to ID
// master drives the stage inputs; slave is the stage itself.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [STALL_BUS-1:0] stall;
  ex_to_mem_t           ex_to_mem_bus;
  logic [31:0]          data_sram_rdata;
  mem_to_wb_t           mem_to_wb_bus;
  mem_to_rf_t           mem_to_rf_bus;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data alignment and extension.
//   mem_op      {lb, lbu, lh, lhu, lw}
//   addr        low two address bits
//   rdata       raw 32-bit word
//   load_result aligned, sign/zero-extended value (0 for non-loads)
module load_align (
  input  logic [4:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_result
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = rdata[{addr, 3'b000} +: 8];
    // halfword select ignores addr[0]; misalignment is not trapped here
    half_v      = addr[1] ? rdata[31:16] : rdata[15:0];
    load_result = '0;
    if (mem_op[4])      load_result = {{24{byte_v[7]}}, byte_v};
    else if (mem_op[3]) load_result = {24'b0, byte_v};
    else if (mem_op[2]) load_result = {{16{half_v[15]}}, half_v};
    else if (mem_op[1]) load_result = {16'b0, half_v};
    else if (mem_op[0]) load_result = rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//   clk  rising-edge clock
//   rst  async active-high reset
//   mif  stage bus (stall, EX->MEM in, SRAM rdata in, WB/RF buses out)
// Registers the EX->MEM bus, keeps SRAM read data in a one-entry hold
// buffer while MEM->WB is stalled, and builds the writeback/bypass buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave mif
);
  ex_to_mem_t  bus_r;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic [31:0] rdata;
  logic [31:0] load_result;
  logic [31:0] rf_wdata;
  logic [7:0]  op_v;
  logic        s_exm, s_mwb;
  logic        bubble, advance;

  assign s_exm   = mif.stall[STALL_EX_MEM];
  assign s_mwb   = mif.stall[STALL_MEM_WB];
  // bus_r takes either a new instruction or a bubble
  assign bubble  = (s_exm == STOP) && (s_mwb == NO_STOP);
  assign advance = (s_exm == NO_STOP) || bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 bus_r <= '0;
    else if (bubble)         bus_r <= '0;
    else if (s_exm == NO_STOP) bus_r <= mif.ex_to_mem_bus;
  end

  // SRAM data is only valid the cycle after the request, so a load that
  // cannot leave MEM keeps its first returned word here. Advance wins
  // over capture so a departing load never leaves stale data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (advance) begin
      hold_valid <= 1'b0;
    end else if (is_load(bus_r.mem_op) && !hold_valid && s_mwb == STOP) begin
      hold_valid <= 1'b1;
      hold_data  <= mif.data_sram_rdata;
    end
  end

  assign rdata = hold_valid ? hold_data : mif.data_sram_rdata;
  assign op_v  = bus_r.mem_op;

  load_align u_align (
    .mem_op      (op_v[7:3]),
    .addr        (bus_r.ex_result[1:0]),
    .rdata       (rdata),
    .load_result (load_result)
  );

  assign rf_wdata = bus_r.sel_rf_res ? load_result : bus_r.ex_result;

  assign mif.mem_to_wb_bus = '{hilo_bus: bus_r.hilo_bus, pc: bus_r.pc,
                               rf_we: bus_r.rf_we, rf_waddr: bus_r.rf_waddr,
                               rf_wdata: rf_wdata};
  assign mif.mem_to_rf_bus = '{hilo_bus: bus_r.hilo_bus, rf_we: bus_r.rf_we,
                               rf_waddr: bus_r.rf_waddr, rf_wdata: rf_wdata};

  // store-side controls and other stall bits are consumed elsewhere
  logic unused_ok;
  assign unused_ok = ^{mif.stall[2:0], mif.stall[5], bus_r.ram_en,
                       bus_r.ram_wen, bus_r.ram_sel, op_v[2:0]};
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if mif ();
  mem_stage dut (.clk(clk), .rst(rst), .mif(mif));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the instruction sitting in MEM plus the rdata snapshot taken
  // the first cycle a load in MEM is blocked from leaving.
  logic [150:0] m_cur;
  logic         m_snap_v;
  logic [31:0]  m_snap;

  function automatic logic is_ld(logic [7:0] op);
    return op == 8'h80 || op == 8'h40 || op == 8'h20 || op == 8'h10 || op == 8'h08;
  endfunction

  function automatic logic [31:0] ref_load(logic [7:0] op, logic [1:0] off, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      8'h80:   return (b >= 32'd128)   ? b - 32'd256   : b;
      8'h40:   return b;
      8'h20:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      8'h10:   return h;
      8'h08:   return d;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [135:0] ref_wb(logic [150:0] c, logic [31:0] rd_live);
    logic [31:0] d, wd;
    d  = m_snap_v ? m_snap : rd_live;
    wd = c[38] ? ref_load(c[150:143], c[1:0], d) : c[31:0];
    return {c[142:77], c[76:45], c[37], c[36:32], wd};
  endfunction

  function automatic logic [150:0] mk_ex(logic [7:0] op, logic [65:0] hilo, logic [31:0] pc,
                                         logic sel, logic we, logic [4:0] wa, logic [31:0] res);
    return {op, hilo, pc, |op, (op[2:0] != 3'b0), 4'hF, sel, we, wa, res};
  endfunction

  function automatic logic [135:0] mk_wb(logic [65:0] hilo, logic [31:0] pc, logic we,
                                         logic [4:0] wa, logic [31:0] wd);
    return {hilo, pc, we, wa, wd};
  endfunction

  // Called at posedge+1: drive, check, clock, advance model.
  task automatic run_cycle(input logic [5:0] st, input logic [150:0] ex, input logic [31:0] rd,
                           input bit dc, input logic [135:0] dexp, input string tag);
    logic [135:0] e;
    mif.stall           = st;
    mif.ex_to_mem_bus   = ex;
    mif.data_sram_rdata = rd;
    #3;
    e = ref_wb(m_cur, rd);
    chk({tag, ".wb"}, mif.mem_to_wb_bus, e);
    chk({tag, ".rf"}, {32'b0, mif.mem_to_rf_bus}, {32'b0, e[135:70], e[37:0]});
    if (dc) chk({tag, ".dir"}, mif.mem_to_wb_bus, dexp);
    @(posedge clk);
    if (!(st[3] && st[4])) begin
      m_cur    = st[3] ? '0 : ex;
      m_snap_v = 1'b0;
    end else if (is_ld(m_cur[150:143]) && !m_snap_v) begin
      m_snap   = rd;
      m_snap_v = 1'b1;
    end
    #1;
  endtask

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] S3  = 6'b001000;
  localparam logic [5:0] S34 = 6'b011000;

  initial begin
    logic [150:0] i_lb, i_lhu, i_lh, i_lw, i_sw, i_mul, i_lw2, i_lw3, ex;
    logic [65:0]  mul_hilo;
    logic [95:0]  r96;
    logic [7:0]   ops [9];
    logic [7:0]   op;
    logic [5:0]   st;

    ops = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    m_cur = '0; m_snap_v = 1'b0; m_snap = '0;
    mif.stall = '0; mif.ex_to_mem_bus = '0; mif.data_sram_rdata = 32'h5A5A_A5A5;

    // reset state
    #12;
    chk("reset.wb",   mif.mem_to_wb_bus, 136'b0);
    chk("reset.rf",   {32'b0, mif.mem_to_rf_bus}, 136'b0);
    chk("reset.hold", {135'b0, dut.hold_valid}, 136'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    mul_hilo = 66'h3_1234_5678_9ABC_DEF0;
    i_lb  = mk_ex(8'h80, 66'h1, 32'h100, 1'b1, 1'b1, 5'd1, 32'h0000_2003);
    i_lhu = mk_ex(8'h10, 66'h2, 32'h104, 1'b1, 1'b1, 5'd2, 32'h0000_2002);
    i_lh  = mk_ex(8'h20, 66'h3, 32'h108, 1'b1, 1'b1, 5'd3, 32'h0000_2000);
    i_lw  = mk_ex(8'h08, 66'h4, 32'h10C, 1'b1, 1'b1, 5'd4, 32'h0000_2010);
    i_sw  = mk_ex(8'h01, 66'h5, 32'h110, 1'b0, 1'b0, 5'd0, 32'h1000_0040);
    i_mul = mk_ex(8'h00, mul_hilo, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0);
    i_lw2 = mk_ex(8'h08, 66'h6, 32'h200, 1'b1, 1'b1, 5'd7, 32'h0000_3000);
    i_lw3 = mk_ex(8'h08, 66'h7, 32'h204, 1'b1, 1'b1, 5'd8, 32'h0000_3004);

    run_cycle(S0,  i_lb,  32'h0,         0, '0, "lb.issue");
    run_cycle(S0,  i_lhu, 32'h80FF_1234, 1, mk_wb(66'h1, 32'h100, 1, 5'd1, 32'hFFFF_FF80), "lb");
    run_cycle(S0,  i_lh,  32'h8001_0000, 1, mk_wb(66'h2, 32'h104, 1, 5'd2, 32'h0000_8001), "lhu");
    run_cycle(S0,  i_lw,  32'h0000_F00D, 1, mk_wb(66'h3, 32'h108, 1, 5'd3, 32'hFFFF_F00D), "lh");
    run_cycle(S34, i_sw,  32'h1234_5678, 1, mk_wb(66'h4, 32'h10C, 1, 5'd4, 32'h1234_5678), "lw.st1");
    run_cycle(S34, i_sw,  32'hDEAD_BEEF, 1, mk_wb(66'h4, 32'h10C, 1, 5'd4, 32'h1234_5678), "lw.st2");
    run_cycle(S34, i_sw,  32'hDEAD_BEEF, 1, mk_wb(66'h4, 32'h10C, 1, 5'd4, 32'h1234_5678), "lw.st3");
    run_cycle(S0,  i_sw,  32'hDEAD_BEEF, 1, mk_wb(66'h4, 32'h10C, 1, 5'd4, 32'h1234_5678), "lw.rel");
    run_cycle(S3,  i_mul, 32'h0,         1, mk_wb(66'h5, 32'h110, 0, 5'd0, 32'h1000_0040), "sw");
    run_cycle(S0,  i_mul, 32'hFFFF_FFFF, 1, 136'b0, "bubble");
    run_cycle(S0,  '0,    32'h0,         1, mk_wb(mul_hilo, 32'h114, 0, 5'd0, 32'h0), "mult");

    // async reset while a load is held
    run_cycle(S0,  i_lw2, 32'h0,         0, '0, "lw2.issue");
    run_cycle(S34, '0,    32'hAAAA_5555, 1, mk_wb(66'h6, 32'h200, 1, 5'd7, 32'hAAAA_5555), "lw2.st1");
    run_cycle(S34, '0,    32'h5555_AAAA, 1, mk_wb(66'h6, 32'h200, 1, 5'd7, 32'hAAAA_5555), "lw2.st2");
    #2 rst = 1'b1;
    #1;
    chk("arst.wb",   mif.mem_to_wb_bus, 136'b0);
    chk("arst.rf",   {32'b0, mif.mem_to_rf_bus}, 136'b0);
    chk("arst.hold", {135'b0, dut.hold_valid}, 136'b0);
    m_cur = '0; m_snap_v = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_cycle(S0, i_lw3, 32'h0,         0, '0, "lw3.issue");
    run_cycle(S0, '0,    32'hCAFE_F00D, 1, mk_wb(66'h7, 32'h204, 1, 5'd8, 32'hCAFE_F00D), "lw3");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      op  = ops[$urandom_range(0, 8)];
      r96 = {$urandom, $urandom, $urandom};
      ex  = mk_ex(op, r96[65:0], $urandom, is_ld(op), $urandom_range(0, 1),
                  5'($urandom_range(0, 31)), $urandom);
      st  = 6'($urandom_range(0, 63));
      st[3] = ($urandom_range(0, 2) == 0);
      st[4] = ($urandom_range(0, 2) == 0);
      run_cycle(st, ex, $urandom, 0, '0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
